cu_ifetch_prefetch: RTL and testbench

Instruction prefetch buffer between the CU core's fetch port and the instruction memory port. Streams sequential 32-bit words (address step 4) ahead of the core into a small FIFO. Serves core fetches that match the expected next address from the buffer. Redirects and discards in-flight data on any non-sequential fetch.

---
 rtl/cu_ifetch_prefetch.sv | 198 +++++++++++++++++++
 tb/tb_cu_ifetch_prefetch.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cu_ifetch_prefetch.sv
// cu_ifetch_prefetch
//   Instruction prefetch buffer between the CU core fetch port and the
//   instruction memory read port. While running it streams sequential words
//   (byte address step 4) ahead of the core into a small FIFO. A core fetch
//   that matches the expected next address is served from the FIFO head. Any
//   other fetch redirects the stream and discards data still in flight.
//
// Parameters
//   DEPTH  FIFO entries and max outstanding memory reads (power of 2, >= 2)
//   AW     fetch address width
//   DW     instruction word width
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   flush_i              drop buffer and in-flight data, go idle
//   core_fetch_req/addr  core fetch request and byte address
//   core_fetch_gnt       fetch accepted this cycle (combinational)
//   core_fetch_r_valid/r_data   returned word, one cycle after gnt
//   mem_req/mem_addr     memory read request and address
//   mem_gnt              memory accepted mem_req this cycle
//   mem_r_valid/r_data   in-order read data from memory
//   perf_hit_cnt/perf_miss_cnt  served-fetch / redirect counters
//
// Build option
//   CU_IFETCH_PERF_EN    when defined, the perf counters are implemented
//                        (16-bit, saturating). Otherwise both ports are 0.
module cu_ifetch_prefetch #(
    parameter int DEPTH = 4,
    parameter int AW    = 19,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush_i,
    input  logic          core_fetch_req,
    input  logic [AW-1:0] core_fetch_addr,
    output logic          core_fetch_gnt,
    output logic [DW-1:0] core_fetch_r_data,
    output logic          core_fetch_r_valid,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_gnt,
    input  logic [DW-1:0] mem_r_data,
    input  logic          mem_r_valid,
    output logic [15:0]   perf_hit_cnt,
    output logic [15:0]   perf_miss_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [AW-1:0] ADDR_STEP = AW'(4);
    localparam logic [CW:0]   DEPTH_L   = (CW+1)'(DEPTH);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state_reg, state_next;
    logic [AW-1:0] pf_addr_reg, pf_addr_next;
    logic [AW-1:0] exp_addr_reg, exp_addr_next;
    logic [CW-1:0] fifo_cnt_reg, fifo_cnt_next;
    logic [CW-1:0] out_cnt_reg, out_cnt_next;
    logic [CW-1:0] drop_cnt_reg, drop_cnt_next;
    logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [DW-1:0] fifo_mem [DEPTH];
    logic [DW-1:0] r_data_reg;
    logic          r_valid_reg;

    logic          miss, redirect, hit, mem_req_int, mem_fire;
    logic          push, rsp_drop, rsp_any;
    logic [CW:0]   fill_sum, fly_sum;

    // flush_i overrides any core request in the same cycle.
    assign miss     = !flush_i && core_fetch_req &&
                      (state_reg == IDLE || core_fetch_addr != exp_addr_reg);
    assign redirect = flush_i || miss;
    assign hit      = !flush_i && core_fetch_req && state_reg == RUN &&
                      core_fetch_addr == exp_addr_reg && fifo_cnt_reg != '0;

    // Buffer room counts words still in flight; outstanding limit includes
    // the responses that will be thrown away.
    assign fill_sum    = {1'b0, fifo_cnt_reg} + {1'b0, out_cnt_reg};
    assign fly_sum     = {1'b0, out_cnt_reg} + {1'b0, drop_cnt_reg};
    assign mem_req_int = state_reg == RUN && !redirect &&
                         fill_sum < DEPTH_L && fly_sum < DEPTH_L;
    assign mem_fire    = mem_req_int && mem_gnt;

    // A response with nothing outstanding (a request granted before reset)
    // is ignored so the counters cannot wrap.
    assign rsp_any  = mem_r_valid && (drop_cnt_reg != '0 || out_cnt_reg != '0);
    assign rsp_drop = mem_r_valid && drop_cnt_reg != '0;
    assign push     = mem_r_valid && !redirect && drop_cnt_reg == '0 &&
                      out_cnt_reg != '0;

    always_comb begin
        state_next    = state_reg;
        pf_addr_next  = pf_addr_reg;
        exp_addr_next = exp_addr_reg;
        fifo_cnt_next = fifo_cnt_reg;
        out_cnt_next  = out_cnt_reg;
        drop_cnt_next = drop_cnt_reg;
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        if (redirect) begin
            // Everything still in flight becomes junk; a response arriving in
            // this very cycle is part of it and is consumed right away.
            fifo_cnt_next = '0;
            wr_ptr_next   = '0;
            rd_ptr_next   = '0;
            out_cnt_next  = '0;
            drop_cnt_next = drop_cnt_reg + out_cnt_reg - CW'(rsp_any);
            if (miss) begin
                state_next    = RUN;
                pf_addr_next  = core_fetch_addr;
                exp_addr_next = core_fetch_addr;
            end else begin
                state_next = IDLE;
            end
        end else begin
            drop_cnt_next = drop_cnt_reg - CW'(rsp_drop);
            out_cnt_next  = out_cnt_reg + CW'(mem_fire) - CW'(push);
            fifo_cnt_next = fifo_cnt_reg + CW'(push) - CW'(hit);
            wr_ptr_next   = wr_ptr_reg + PW'(push);
            rd_ptr_next   = rd_ptr_reg + PW'(hit);
            if (hit) begin
                exp_addr_next = exp_addr_reg + ADDR_STEP;
            end
            if (mem_fire) begin
                pf_addr_next = pf_addr_reg + ADDR_STEP;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            pf_addr_reg  <= '0;
            exp_addr_reg <= '0;
            fifo_cnt_reg <= '0;
            out_cnt_reg  <= '0;
            drop_cnt_reg <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            r_valid_reg  <= 1'b0;
            r_data_reg   <= '0;
        end else begin
            state_reg    <= state_next;
            pf_addr_reg  <= pf_addr_next;
            exp_addr_reg <= exp_addr_next;
            fifo_cnt_reg <= fifo_cnt_next;
            out_cnt_reg  <= out_cnt_next;
            drop_cnt_reg <= drop_cnt_next;
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            r_valid_reg  <= hit;
            if (hit) begin
                r_data_reg <= fifo_mem[rd_ptr_reg];
            end
        end
    end

    // Storage array kept free of reset so it maps onto RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= mem_r_data;
        end
    end

    assign core_fetch_gnt     = hit;
    assign core_fetch_r_valid = r_valid_reg;
    assign core_fetch_r_data  = r_data_reg;
    assign mem_req            = mem_req_int;
    assign mem_addr           = pf_addr_reg;

`ifdef CU_IFETCH_PERF_EN
    logic [15:0] perf_hit_reg, perf_miss_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_hit_reg  <= '0;
            perf_miss_reg <= '0;
        end else begin
            if (hit && perf_hit_reg != 16'hFFFF) begin
                perf_hit_reg <= perf_hit_reg + 16'd1;
            end
            if (miss && perf_miss_reg != 16'hFFFF) begin
                perf_miss_reg <= perf_miss_reg + 16'd1;
            end
        end
    end

    assign perf_hit_cnt  = perf_hit_reg;
    assign perf_miss_cnt = perf_miss_reg;
`else
    assign perf_hit_cnt  = '0;
    assign perf_miss_cnt = '0;
`endif

endmodule

// File: tb/tb_cu_ifetch_prefetch.sv
// Testbench for cu_ifetch_prefetch: cycle table for the first stream after
// reset, then directed sequences for stall, redirect, wrap, flush and
// miss-with-response. A memory model with selectable latency answers every
// granted request with a data word derived from its address.
module tb_cu_ifetch_prefetch;

    localparam int AW = 19;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush_i = 1'b0;
    logic          core_fetch_req = 1'b0;
    logic [AW-1:0] core_fetch_addr = '0;
    logic          core_fetch_gnt;
    logic [DW-1:0] core_fetch_r_data;
    logic          core_fetch_r_valid;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_gnt = 1'b1;
    logic [DW-1:0] mem_r_data = '0;
    logic          mem_r_valid = 1'b0;
    logic [15:0]   perf_hit_cnt;
    logic [15:0]   perf_miss_cnt;

    cu_ifetch_prefetch #(.DEPTH(4), .AW(AW), .DW(DW)) dut (
        .clk                (clk),
        .rst                (rst),
        .flush_i            (flush_i),
        .core_fetch_req     (core_fetch_req),
        .core_fetch_addr    (core_fetch_addr),
        .core_fetch_gnt     (core_fetch_gnt),
        .core_fetch_r_data  (core_fetch_r_data),
        .core_fetch_r_valid (core_fetch_r_valid),
        .mem_req            (mem_req),
        .mem_addr           (mem_addr),
        .mem_gnt            (mem_gnt),
        .mem_r_data         (mem_r_data),
        .mem_r_valid        (mem_r_valid),
        .perf_hit_cnt       (perf_hit_cnt),
        .perf_miss_cnt      (perf_miss_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          req;
        logic [AW-1:0] addr;
        logic          gnt;
        logic          mreq;
        logic [AW-1:0] maddr;
        logic          rvalid;
        logic [DW-1:0] rdata;
    } vec_t;

    vec_t          vecs [10];
    int            checks = 0;
    int            failures = 0;
    int            cyc = 0;
    int            lat = 1;
    int            tb_fetches = 0;
    int            tb_misses = 0;
    logic [AW-1:0] rsp_addr_q [$];
    int            rsp_due_q [$];
    logic [DW-1:0] exp_rd_q [$];
    logic          prev_gnt = 1'b0;
    logic          saw_zero_req = 1'b0;
    logic          s_gnt, s_mreq, s_rvalid;
    logic [AW-1:0] s_maddr;
    logic [DW-1:0] s_rdata;

    function automatic logic [DW-1:0] memval(input logic [AW-1:0] a);
        return 32'hC0DE0000 ^ {13'd0, a};
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    // One clock cycle: sample outputs at negedge, record memory grants,
    // then drive the memory response for the new cycle just after posedge.
    task automatic tick();
        @(negedge clk);
        s_gnt    = core_fetch_gnt;
        s_mreq   = mem_req;
        s_maddr  = mem_addr;
        s_rvalid = core_fetch_r_valid;
        s_rdata  = core_fetch_r_data;
        check("rvalid_timing", DW'(core_fetch_r_valid), DW'(prev_gnt));
        if (core_fetch_r_valid && exp_rd_q.size() > 0) begin
            check("rdata", core_fetch_r_data, exp_rd_q[0]);
            $display("rdata cyc=%0d data=%h", cyc, core_fetch_r_data);
            void'(exp_rd_q.pop_front());
        end
        if (core_fetch_gnt) begin
            exp_rd_q.push_back(memval(core_fetch_addr));
        end
        prev_gnt = core_fetch_gnt && !rst;
        if (rst) begin
            exp_rd_q.delete();
        end
        if (mem_req && mem_gnt && !rst) begin
            rsp_addr_q.push_back(mem_addr);
            rsp_due_q.push_back(cyc + lat);
            if (mem_addr == '0) begin
                saw_zero_req = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (rsp_due_q.size() > 0 && rsp_due_q[0] == cyc) begin
            mem_r_valid = 1'b1;
            mem_r_data  = memval(rsp_addr_q[0]);
            void'(rsp_addr_q.pop_front());
            void'(rsp_due_q.pop_front());
        end else begin
            mem_r_valid = 1'b0;
            mem_r_data  = '0;
        end
    endtask

    // Fetch n sequential words, holding each request until granted.
    task automatic fetch_seq(input logic [AW-1:0] start, input int n, input bit is_miss,
                             output int first_cyc, output int last_cyc);
        logic [AW-1:0] a;
        int budget;
        first_cyc = -1;
        last_cyc  = -1;
        if (is_miss) begin
            tb_misses++;
        end
        for (int i = 0; i < n; i++) begin
            a = start + AW'(4 * i);
            core_fetch_req  = 1'b1;
            core_fetch_addr = a;
            budget = 0;
            do begin
                tick();
                budget++;
            end while (!s_gnt && budget < 64);
            checks++;
            if (!s_gnt) begin
                failures++;
                $display("FAIL fetch_timeout addr=%h actual=no_gnt expected=gnt", a);
            end else begin
                tb_fetches++;
                $display("fetch addr=%h gnt_cyc=%0d", a, cyc - 1);
            end
            if (i == 0) begin
                first_cyc = cyc;
            end
            last_cyc = cyc;
        end
        core_fetch_req = 1'b0;
    endtask

    // Idle the core until memory traffic has died out.
    task automatic quiesce();
        int b;
        b = 0;
        core_fetch_req = 1'b0;
        flush_i = 1'b0;
        do begin
            tick();
            b++;
        end while ((rsp_addr_q.size() != 0 || mem_req || mem_r_valid) && b < 100);
        tick();
        tick();
        checks++;
        if (b >= 100) begin
            failures++;
            $display("FAIL quiesce_timeout actual=%0d expected<100", b);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int f;
        int l;
        int before_miss;

        vecs[0] = '{1'b1, 19'h00100, 1'b0, 1'b0, 19'h00000, 1'b0, 32'h0};
        vecs[1] = '{1'b1, 19'h00100, 1'b0, 1'b1, 19'h00100, 1'b0, 32'h0};
        vecs[2] = '{1'b1, 19'h00100, 1'b0, 1'b1, 19'h00104, 1'b0, 32'h0};
        vecs[3] = '{1'b1, 19'h00100, 1'b1, 1'b1, 19'h00108, 1'b0, 32'h0};
        vecs[4] = '{1'b1, 19'h00104, 1'b1, 1'b1, 19'h0010C, 1'b1, memval(19'h00100)};
        vecs[5] = '{1'b1, 19'h00108, 1'b1, 1'b1, 19'h00110, 1'b1, memval(19'h00104)};
        vecs[6] = '{1'b1, 19'h0010C, 1'b1, 1'b1, 19'h00114, 1'b1, memval(19'h00108)};
        vecs[7] = '{1'b0, 19'h0010C, 1'b0, 1'b1, 19'h00118, 1'b1, memval(19'h0010C)};
        vecs[8] = '{1'b0, 19'h0010C, 1'b0, 1'b1, 19'h0011C, 1'b0, memval(19'h0010C)};
        vecs[9] = '{1'b0, 19'h0010C, 1'b0, 1'b0, 19'h00120, 1'b0, memval(19'h0010C)};

        // Reset values
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tick();
        check("rst_gnt", DW'(s_gnt), 32'd0);
        check("rst_mem_req", DW'(s_mreq), 32'd0);
        check("rst_mem_addr", DW'(s_maddr), 32'd0);
        check("rst_r_valid", DW'(s_rvalid), 32'd0);
        check("rst_r_data", s_rdata, 32'd0);
        check("rst_perf_hit", DW'(perf_hit_cnt), 32'd0);
        check("rst_perf_miss", DW'(perf_miss_cnt), 32'd0);
        rst = 1'b0;

        // First stream from 0x100 with a 1-cycle memory, then core stalls
        tb_misses++;
        tb_fetches += 4;
        for (int k = 0; k < 10; k++) begin
            core_fetch_req  = vecs[k].req;
            core_fetch_addr = vecs[k].addr;
            tick();
            check("tbl_gnt", DW'(s_gnt), DW'(vecs[k].gnt));
            check("tbl_mem_req", DW'(s_mreq), DW'(vecs[k].mreq));
            check("tbl_mem_addr", DW'(s_maddr), DW'(vecs[k].maddr));
            check("tbl_r_valid", DW'(s_rvalid), DW'(vecs[k].rvalid));
            check("tbl_r_data", s_rdata, vecs[k].rdata);
        end

        // Remaining stall cycles: buffer full, no requests
        repeat (7) begin
            tick();
            check("stall_mem_req", DW'(s_mreq), 32'd0);
        end
        before_miss = cyc;
        fetch_seq(19'h00110, 4, 1'b0, f, l);
        check("stall_first_gnt", DW'(f - before_miss), 32'd1);
        check("stall_back_to_back", DW'(l - f), 32'd3);

        // Redirect with responses in flight (3-cycle memory)
        quiesce();
        lat = 3;
        fetch_seq(19'h00300, 2, 1'b1, f, l);
        before_miss = int'(perf_miss_cnt);
        fetch_seq(19'h00200, 4, 1'b1, f, l);
`ifdef CU_IFETCH_PERF_EN
        check("perf_miss_step", DW'(perf_miss_cnt), DW'(before_miss + 1));
`endif

        // Stream across the top of the address space
        quiesce();
        lat = 1;
        saw_zero_req = 1'b0;
        fetch_seq(19'h7FFF8, 4, 1'b1, f, l);
        check("wrap_req_zero", DW'(saw_zero_req), 32'd1);

        // Flush with three requests outstanding (4-cycle memory)
        quiesce();
        lat = 4;
        core_fetch_req  = 1'b1;
        core_fetch_addr = 19'h00500;
        tb_misses++;
        tick();
        core_fetch_req = 1'b0;
        repeat (3) begin
            tick();
            check("pre_flush_mem_req", DW'(s_mreq), 32'd1);
        end
        flush_i         = 1'b1;
        core_fetch_req  = 1'b1;
        core_fetch_addr = 19'h00800;
        tick();
        check("flush_mem_req", DW'(s_mreq), 32'd0);
        check("flush_gnt", DW'(s_gnt), 32'd0);
        flush_i        = 1'b0;
        core_fetch_req = 1'b0;
        repeat (6) begin
            tick();
            check("idle_mem_req", DW'(s_mreq), 32'd0);
        end
        lat = 1;
        fetch_seq(19'h00040, 3, 1'b1, f, l);

        // Redirect in the same cycle as a response with nothing to drop
        quiesce();
        fetch_seq(19'h00600, 3, 1'b1, f, l);
        check("miss_rsp_overlap", DW'(mem_r_valid), 32'd1);
        fetch_seq(19'h00700, 3, 1'b1, f, l);
        quiesce();

`ifdef CU_IFETCH_PERF_EN
        check("perf_hits", DW'(perf_hit_cnt), DW'(tb_fetches));
        check("perf_misses", DW'(perf_miss_cnt), DW'(tb_misses));
`endif

        // Reset mid-operation, then a clean restart
        rst = 1'b1;
        tick();
        tick();
        check("rst2_mem_req", DW'(s_mreq), 32'd0);
        check("rst2_mem_addr", DW'(s_maddr), 32'd0);
        check("rst2_r_valid", DW'(s_rvalid), 32'd0);
        check("rst2_r_data", s_rdata, 32'd0);
        check("rst2_perf_hit", DW'(perf_hit_cnt), 32'd0);
        rst = 1'b0;
        fetch_seq(19'h00010, 2, 1'b1, f, l);
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
